case_lut_arb: RTL and testbench
===============================

CASE_LUT_ARB -- requirements
Module: case_lut_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 4, lookup address width; table depth 2**AW entries of 1 bit.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one requester (used only with the lock feature).
REQ-004 clk  input  1  rising-edge clock, the single clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_we  input  1  table write strobe.
REQ-007 cfg_addr  input  AW  table write address.
REQ-008 cfg_data  input  1  table write data.
REQ-009 req  input  NREQ  per-requester lookup request, level.
REQ-010 addr  input  NREQ*AW  per-requester lookup address; slice i is addr[i*AW +: AW].
REQ-011 gnt  output  NREQ  one-hot grant, combinational from req and registered state.
REQ-012 vld  output  1  lookup result valid.
REQ-013 q  output  1  lookup result.
REQ-014 q_id  output  clog2(NREQ)  index of the requester that owns q.

Function
REQ-015 SHALL grant at most one requester per cycle; a request is accepted in a cycle where req[i] and gnt[i] are both 1.
REQ-016 SHALL produce no grant in any cycle with cfg_we=1; table writes have absolute priority.
REQ-017 Table write SHALL take effect at the clk edge ending the cycle in which cfg_we=1.
REQ-018 The accepted lookup SHALL return vld=1, q=table[addr slice], and q_id=granted index exactly 1 cycle after acceptance; otherwise vld=0, with q and q_id holding their last values.
REQ-019 Round-robin: a search SHALL start at index (last_granted+1) mod NREQ and grant the first requester with req=1.
REQ-020 The pointer SHALL update only on acceptance.
REQ-021 A lookup accepted in the cycle after a write to the same address SHALL return the new data.
REQ-022 With req all zero, gnt SHALL be 0, vld SHALL go 0 next cycle, and the pointer SHALL hold.
REQ-023 Deasserting req[i] in the grant cycle SHALL cancel that grant; there is no request queueing.

Reset
REQ-024 On rst_n=0, asynchronously: vld=0, q=0, q_id=0, last_granted=NREQ-1 (requester 0 has highest priority first), burst counter=0, all table entries=0.
REQ-025 Reset asserted mid-lookup SHALL drop the pending result; vld SHALL stay 0 after release until a new acceptance.

Configuration
REQ-026 Macro CASE_LUT_ARB_LOCK_EN SHALL compile in grant locking.
REQ-027 With CASE_LUT_ARB_LOCK_EN defined: a requester accepted in the previous cycle whose req is still 1 SHALL be granted again, ahead of round-robin order, until it has MAX_BURST consecutive acceptances.
REQ-028 With CASE_LUT_ARB_LOCK_EN defined: after MAX_BURST consecutive acceptances, arbitration SHALL resume round-robin from the next index.
REQ-029 With CASE_LUT_ARB_LOCK_EN defined: a cfg_we cycle or a req drop SHALL clear the burst counter.
REQ-030 With CASE_LUT_ARB_LOCK_EN undefined: the burst counter and MAX_BURST SHALL be unused, and grants SHALL rotate strictly every acceptance.

Structure
REQ-031 A shared package case_lut_pkg SHALL hold the AW default, NREQ default, MAX_BURST default, and an id-width function clog2.
REQ-032 Arbitration SHALL live in a sub-module rr_arb (req, pointer in; one-hot gnt and encoded index out).
REQ-033 The table and result registers SHALL live in the top level.

Verification
REQ-034 Reset test: release reset, req=4'b1111 with all addr=0 -> gnt=0001, 0010, 0100, 1000, 0001 on consecutive cycles (lock off); vld=1 with q=0 from the second cycle.
REQ-035 Write priority: cfg_we=1, cfg_addr=6, cfg_data=1 while req=4'b0100 -> gnt=0 that cycle. Next cycle, gnt=0100 with addr slice 2=6 -> one cycle later vld=1, q=1, q_id=2.
REQ-036 Table program: write entries {0,1,4,6,7}=1 and {2,3,5}=0, then sweep addresses 0..7 through requester 1 -> q sequence 1,1,0,0,1,0,1,1.
REQ-037 Fairness: req=4'b1010 held for 8 cycles (lock off) -> gnt alternates 0010/1000, each granted 4 times.
REQ-038 Lock: with CASE_LUT_ARB_LOCK_EN, MAX_BURST=4, req=4'b0011 held -> gnt=0001 x4, 0010 x4, 0001 x4.
REQ-039 Lock break: with CASE_LUT_ARB_LOCK_EN, req[0] dropped after 2 grants -> requester 1 is granted next cycle.
REQ-040 Mid-operation reset: rst_n pulsed low in the cycle after an acceptance -> vld=0, and the table reads 0 on the next lookup.

Source files
------------

// File: rtl/case_lut_pkg.sv
// Shared defaults and the id-width helper for the case_lut_arb slice.
package case_lut_pkg;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned AW_DEF        = 4;
  localparam int unsigned MAX_BURST_DEF = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/case_lut_arb_rr.sv
// rr_arb: round-robin pick of the first requester after ptr (the last granted index).
module rr_arb
  import case_lut_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic            found;
  logic [NREQ-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = NREQ'(1) << ((32'(ptr) + k) % NREQ);
      if (!found && ((req & cand) != '0)) begin
        found = 1'b1;
        gnt   = cand;
        idx   = IW'((32'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/case_lut_arb.sv
// case_lut_arb: 1-bit lookup table shared by NREQ round-robin requesters.
// Define CASE_LUT_ARB_LOCK_EN to let a requester keep the grant for up to MAX_BURST acceptances.
module case_lut_arb
  import case_lut_pkg::*;
#(
  parameter  int unsigned NREQ      = NREQ_DEF,
  parameter  int unsigned AW        = AW_DEF,
  parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
  localparam int unsigned IW        = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic               cfg_data,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic               vld,
  output logic               q,
  output logic [IW-1:0]      q_id
);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1) begin : g_cfg_check
    $error("case_lut_arb: unsupported parameter set");
  end

  logic [2**AW-1:0] tbl;
  logic [IW-1:0]    last;
  logic [NREQ-1:0]  rr_req;
  logic [NREQ-1:0]  rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic [IW-1:0]    gnt_idx;
  logic [AW-1:0]    sel_addr;
  logic             acc;

  // Table writes win: masking the arbiter input suppresses every grant.
  assign rr_req = cfg_we ? '0 : req;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req (rr_req),
    .ptr (last),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

`ifdef CASE_LUT_ARB_LOCK_EN
  localparam int unsigned BW = clog2(MAX_BURST + 1);

  logic [BW-1:0] burst;
  logic          lock_hit;

  // A nonzero burst means 'last' was accepted in the previous cycle.
  assign lock_hit = !cfg_we && req[last] && (burst != '0) && (burst < BW'(MAX_BURST));
  assign gnt      = lock_hit ? (NREQ'(1) << last) : rr_gnt;
  assign gnt_idx  = lock_hit ? last : rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        burst <= '0;
    else if (!acc)     burst <= '0;
    else if (lock_hit) burst <= burst + BW'(1);
    else               burst <= BW'(1);
  end
`else
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
`endif

  assign acc = |gnt;

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (gnt[i]) sel_addr = addr[i*AW +: AW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl  <= '0;
      vld  <= 1'b0;
      q    <= 1'b0;
      q_id <= '0;
      last <= IW'(NREQ - 1);
    end else begin
      if (cfg_we) tbl[cfg_addr] <= cfg_data;
      vld <= acc;
      if (acc) begin
        q    <= tbl[sel_addr];
        q_id <= gnt_idx;
        last <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_case_lut_arb.sv
// Bench for case_lut_arb: directed vector table, reset corner cases and random traffic
// against a behavioural model of the table and round-robin rules.
module tb_case_lut_arb;

  localparam int N  = 4;
  localparam int MB = 4;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic        cfg_data;
  logic [3:0]  req;
  logic [15:0] addr;
  logic [3:0]  gnt;
  logic        vld;
  logic        q;
  logic [1:0]  q_id;

  case_lut_arb #(.NREQ(N), .AW(4), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .vld      (vld),
    .q        (q),
    .q_id     (q_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rs;
    bit        we;
    bit [3:0]  wa;
    bit        wd;
    bit [3:0]  r;
    bit [15:0] a;
    bit [3:0]  g;
    bit        v;
    bit        q;
    bit [1:0]  id;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_fail;

  // Behavioural model state
  bit mt[16];
  int mlast;
  int mburst;
  bit mvld;
  bit mq;
  int mqid;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mt[i]) mt[i] = 1'b0;
    mlast  = N - 1;
    mburst = 0;
    mvld   = 1'b0;
    mq     = 1'b0;
    mqid   = 0;
  endtask

  function automatic int model_pick(input bit we, input bit [3:0] r);
    if (we) return -1;
`ifdef CASE_LUT_ARB_LOCK_EN
    if (mburst > 0 && mburst < MB && r[2'(mlast)]) return mlast;
`endif
    for (int k = 1; k <= N; k++)
      if (r[2'((mlast + k) % N)]) return (mlast + k) % N;
    return -1;
  endfunction

  task automatic step(input bit we, input bit [3:0] wa, input bit wd,
                      input bit [3:0] r, input bit [15:0] a, output bit [3:0] gs);
    int        eg;
    bit [15:0] sh;
    cfg_we   = we;
    cfg_addr = wa;
    cfg_data = wd;
    req      = r;
    addr     = a;
    #1;
    eg = model_pick(we, r);
    gs = gnt;
    chk("gnt", int'(gnt), (eg < 0) ? 0 : (1 << eg));
    if (eg >= 0) begin
      sh   = a >> (4 * eg);
      mq   = mt[sh[3:0]];
      mvld = 1'b1;
      mqid = eg;
      if (eg == mlast && mburst > 0 && mburst < MB) mburst++;
      else mburst = 1;
      mlast = eg;
    end else begin
      mvld   = 1'b0;
      mburst = 0;
    end
    if (we) mt[wa] = wd;
    @(posedge clk);
    #1;
    chk("vld", int'(vld), int'(mvld));
    chk("q", int'(q), int'(mq));
    chk("q_id", int'(q_id), mqid);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = 1'b0;
    req      = '0;
    addr     = '0;
    model_reset();
    #2;
    chk("rst_vld", int'(vld), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_qid", int'(q_id), 0);
    chk("rst_gnt", int'(gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit rs, input bit we, input bit [3:0] wa, input bit wd,
                     input bit [3:0] r, input bit [15:0] a, input bit [3:0] g,
                     input bit v, input bit qq, input bit [1:0] id);
    vec_t e;
    e = '{rs, we, wa, wd, r, a, g, v, qq, id};
    vq.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [3:0] gs;
    bit [7:0] pat;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    cfg_we = 1'b0;
    req    = '0;
    addr   = '0;
    #1;
    do_reset();

    pat = 8'b1101_0011;
`ifndef CASE_LUT_ARB_LOCK_EN
    add(0, 0, 0, 0, 4'hF, 16'h0, 4'h1, 1, 0, 0);
    add(0, 0, 0, 0, 4'hF, 16'h0, 4'h2, 1, 0, 1);
    add(0, 0, 0, 0, 4'hF, 16'h0, 4'h4, 1, 0, 2);
    add(0, 0, 0, 0, 4'hF, 16'h0, 4'h8, 1, 0, 3);
    add(0, 0, 0, 0, 4'hF, 16'h0, 4'h1, 1, 0, 0);
`endif
    add(1, 1, 6, 1, 4'h4, 16'h0600, 4'h0, 0, 0, 0);
    add(0, 0, 0, 0, 4'h4, 16'h0600, 4'h4, 1, 1, 2);
    for (int k = 0; k < 8; k++) add(0, 1, 4'(k), pat[3'(k)], 4'h0, 16'h0, 4'h0, 0, 1, 2);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 4'h2, 16'(k << 4), 4'h2, 1, pat[3'(k)], 1);
    add(0, 1, 8, 1, 4'h8, 16'h8000, 4'h0, 0, 1, 1);
    add(0, 0, 0, 0, 4'h8, 16'h8000, 4'h8, 1, 1, 3);
    add(0, 1, 8, 0, 4'h8, 16'h8000, 4'h0, 0, 1, 3);
    add(0, 0, 0, 0, 4'h8, 16'h8000, 4'h8, 1, 0, 3);
    add(0, 0, 0, 0, 4'h0, 16'h0, 4'h0, 0, 0, 3);
`ifndef CASE_LUT_ARB_LOCK_EN
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0, 4'hA, 16'h0, (k % 2 == 0) ? 4'h2 : 4'h8, 1, 1, (k % 2 == 0) ? 2'd1 : 2'd3);
`else
    for (int k = 0; k < 12; k++)
      add((k == 0), 0, 0, 0, 4'h3, 16'h0, (k / 4 == 1) ? 4'h2 : 4'h1, 1, 0, (k / 4 == 1) ? 2'd1 : 2'd0);
    add(1, 0, 0, 0, 4'h3, 16'h0, 4'h1, 1, 0, 0);
    add(0, 0, 0, 0, 4'h3, 16'h0, 4'h1, 1, 0, 0);
    add(0, 0, 0, 0, 4'h2, 16'h0, 4'h2, 1, 0, 1);
    add(0, 0, 0, 0, 4'h3, 16'h0, 4'h2, 1, 0, 1);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rs) do_reset();
      step(vq[i].we, vq[i].wa, vq[i].wd, vq[i].r, vq[i].a, gs);
      chk($sformatf("vec%0d_gnt", i), int'(gs), int'(vq[i].g));
      chk($sformatf("vec%0d_vld", i), int'(vld), int'(vq[i].v));
      chk($sformatf("vec%0d_q", i), int'(q), int'(vq[i].q));
      chk($sformatf("vec%0d_qid", i), int'(q_id), int'(vq[i].id));
    end

    // Reset landing in the cycle after an acceptance must drop the result and clear the table.
    step(1, 5, 1, 4'h0, 16'h0, gs);
    step(0, 0, 0, 4'h1, 16'h0005, gs);
    chk("pre_rst_q", int'(q), 1);
    do_reset();
    step(0, 0, 0, 4'h0, 16'h0, gs);
    chk("post_rst_idle_vld", int'(vld), 0);
    step(0, 0, 0, 4'h1, 16'h0005, gs);
    chk("post_rst_q", int'(q), 0);
    chk("post_rst_vld", int'(vld), 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 16'($urandom), gs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
